// File: rtl/spi_regs_pkg.sv
// Shared constants and FSM encoding for the SPI control-register peripheral.
package spi_regs_pkg;

    localparam int FRAME_BITS = 16;
    localparam int CNT_W      = 5;

    localparam logic [CNT_W-1:0] CNT_FULL     = 5'd16;
    localparam logic [CNT_W-1:0] CNT_OVERLONG = 5'd17;

    localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;
    localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;
    localparam logic [6:0] ADDR_EN_PWM_LO = 7'h02;
    localparam logic [6:0] ADDR_EN_PWM_HI = 7'h03;
    localparam logic [6:0] ADDR_DUTY      = 7'h04;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer for one asynchronous pin, plus a history flop
// that yields single-cycle rise/fall strobes on the synchronized value.
module sync_edge_det #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
            prev  <= 1'b0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
            prev  <= chain[STAGES-1];
        end
    end

    assign sync = chain[STAGES-1];
    assign rise = sync & ~prev;
    assign fall = ~sync & prev;

endmodule

// File: rtl/spi_peripheral.sv
// Write-only SPI mode-0 target holding five 8-bit control registers for the PWM block.
//
//   state  | meaning
//   -------+----------------------------------------------------------
//   IDLE   | chip deselected; waiting for synced ncs to fall
//   SHIFT  | frame in progress; sampling copi on each synced sclk rise
//   COMMIT | one cycle after ncs rise; apply the frame if well-formed
module spi_peripheral
    import spi_regs_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [6:0] MAX_ADDR    = 7'h04
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ncs,
    input  logic       sclk,
    input  logic       copi,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle
);

    logic ncs_s, ncs_rise, ncs_fall;
    logic sclk_s, sclk_rise, sclk_fall;
    logic copi_s, copi_rise, copi_fall;

    sync_edge_det #(.STAGES(SYNC_STAGES)) u_sync_ncs (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (ncs),
        .sync (ncs_s),
        .rise (ncs_rise),
        .fall (ncs_fall)
    );

    sync_edge_det #(.STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (sclk),
        .sync (sclk_s),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    sync_edge_det #(.STAGES(SYNC_STAGES)) u_sync_copi (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (copi),
        .sync (copi_s),
        .rise (copi_rise),
        .fall (copi_fall)
    );

    // Only the levels/strobes actually needed by the frame logic are consumed.
    logic unused_sync;
    assign unused_sync = &{1'b0, ncs_s, sclk_s, sclk_fall, copi_rise, copi_fall};

    state_t                  state, state_nx;
    logic [FRAME_BITS-1:0]   shreg;
    logic [CNT_W-1:0]        bit_cnt;
    logic                    frame_clr;
    logic                    shift_en;
    logic                    cnt_inc;
    logic                    wr_en;

    logic [6:0] frame_addr;
    logic [7:0] frame_data;
    assign frame_addr = shreg[14:8];
    assign frame_data = shreg[7:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        frame_clr = 1'b0;
        shift_en  = 1'b0;
        cnt_inc   = 1'b0;
        wr_en     = 1'b0;
        case (state)
            IDLE: begin
                if (ncs_fall) begin
                    frame_clr = 1'b1;
                    state_nx  = SHIFT;
                end
            end
            SHIFT: begin
                // A bit arriving together with ncs_rise still lands before COMMIT looks at it.
                if (sclk_rise) begin
                    shift_en = (bit_cnt < CNT_FULL);
                    cnt_inc  = (bit_cnt < CNT_OVERLONG);
                end
                if (ncs_rise) state_nx = COMMIT;
            end
            COMMIT: begin
                wr_en    = (bit_cnt == CNT_FULL) && shreg[15] && (frame_addr <= MAX_ADDR);
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else if (frame_clr) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else begin
            if (shift_en) shreg   <= {shreg[FRAME_BITS-2:0], copi_s};
            if (cnt_inc)  bit_cnt <= bit_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_reg_out_7_0  <= 8'h00;
            en_reg_out_15_8 <= 8'h00;
            en_reg_pwm_7_0  <= 8'h00;
            en_reg_pwm_15_8 <= 8'h00;
            pwm_duty_cycle  <= 8'h00;
        end else if (wr_en) begin
            case (frame_addr)
                ADDR_EN_OUT_LO: en_reg_out_7_0  <= frame_data;
                ADDR_EN_OUT_HI: en_reg_out_15_8 <= frame_data;
                ADDR_EN_PWM_LO: en_reg_pwm_7_0  <= frame_data;
                ADDR_EN_PWM_HI: en_reg_pwm_15_8 <= frame_data;
                ADDR_DUTY:      pwm_duty_cycle  <= frame_data;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_peripheral.sv
// Scoreboard bench for spi_peripheral: SPI frames are bit-banged on the pins,
// a register-array model predicts the outcome, and a monitor checks timing and values.
`timescale 1ns/1ps
module tb_spi_peripheral;

    localparam int SYNC = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ncs = 1'b1;
    logic       sclk = 1'b0;
    logic       copi = 1'b0;
    logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;

    spi_peripheral #(.SYNC_STAGES(SYNC), .MAX_ADDR(7'h04)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ncs            (ncs),
        .sclk           (sclk),
        .copi           (copi),
        .en_reg_out_7_0 (en_reg_out_7_0),
        .en_reg_out_15_8(en_reg_out_15_8),
        .en_reg_pwm_7_0 (en_reg_pwm_7_0),
        .en_reg_pwm_15_8(en_reg_pwm_15_8),
        .pwm_duty_cycle (pwm_duty_cycle)
    );

    always #50 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    logic [39:0] dut_vec;
    assign dut_vec = {pwm_duty_cycle, en_reg_pwm_15_8, en_reg_pwm_7_0, en_reg_out_15_8, en_reg_out_7_0};

    // Reference: five plain registers indexed by address.
    logic [7:0] model [5];

    function automatic logic [39:0] model_vec();
        return {model[4], model[3], model[2], model[1], model[0]};
    endfunction

    typedef struct {
        int          cyc;
        logic [39:0] prev;
        logic [39:0] exp;
    } exp_t;
    exp_t sb[$];

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, req);
        end
    endtask

    // Outputs must hold the old value one cycle before the deadline and show the new one on it.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            if (cyc == sb[0].cyc + SYNC + 1) begin
                check("pre_commit_hold", dut_vec, sb[0].prev);
            end else if (cyc == sb[0].cyc + SYNC + 2) begin
                check("commit_value", dut_vec, sb[0].exp);
                void'(sb.pop_front());
            end
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // word[nbits-1] is sent first.
    task automatic send_frame(input int nbits, input logic [31:0] word, input int hp, input int gap);
        exp_t e;
        logic [6:0] addr;
        ncs = 1'b0;
        wait_clk(2);
        for (int i = nbits - 1; i >= 0; i--) begin
            copi = word[i];
            wait_clk(hp);
            sclk = 1'b1;
            wait_clk(hp);
            sclk = 1'b0;
        end
        wait_clk(hp);
        ncs = 1'b1;
        e.cyc  = cyc;
        e.prev = model_vec();
        addr   = word[14:8];
        if (nbits == 16 && word[15] && addr <= 7'd4) model[addr] = word[7:0];
        e.exp = model_vec();
        sb.push_back(e);
        wait_clk(gap);
    endtask

    task automatic send16(input logic rw, input logic [6:0] addr, input logic [7:0] data,
                          input int hp, input int gap);
        send_frame(16, {16'h0, rw, addr, data}, hp, gap);
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() > 0 && t < 400) begin
            wait_clk(1);
            t++;
        end
        if (sb.size() > 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_timeout: %0d entries left, expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic all_regs(input int hp);
        send16(1'b1, 7'h00, 8'hF0, hp, 3);
        send16(1'b1, 7'h01, 8'h0F, hp, 3);
        send16(1'b1, 7'h02, 8'hCC, hp, 3);
        send16(1'b1, 7'h03, 8'h33, hp, 3);
        send16(1'b1, 7'h04, 8'h80, hp, 3);
        drain();
        check("all_regs_final", dut_vec, 40'h80_33_CC_0F_F0);
    endtask

    initial begin
        #20000000;
        $display("FAIL watchdog: simulation time exceeded, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 5; i++) model[i] = 8'h00;
        wait_clk(3);
        check("reset_state", dut_vec, 40'h0);
        rst_n = 1'b1;
        wait_clk(4);

        all_regs(5);

        // Reset arriving mid-frame must clear everything and leave no partial frame.
        ncs = 1'b0;
        wait_clk(2);
        for (int i = 7; i >= 0; i--) begin
            copi = 1'b1;
            wait_clk(4);
            sclk = 1'b1;
            wait_clk(4);
            sclk = 1'b0;
        end
        rst_n = 1'b0;
        wait_clk(2);
        check("mid_frame_reset", dut_vec, 40'h0);
        for (int i = 0; i < 5; i++) model[i] = 8'h00;
        ncs  = 1'b1;
        copi = 1'b0;
        wait_clk(1);
        rst_n = 1'b1;
        wait_clk(4);
        send16(1'b1, 7'h00, 8'hA5, 4, 3);
        drain();

        all_regs(4);

        send16(1'b1, 7'h05, 8'hFF, 4, 3);
        send16(1'b0, 7'h04, 8'h12, 4, 3);
        send16(1'b1, 7'h7F, 8'h77, 4, 3);
        send_frame(15, {16'h0, 1'b1, 7'h04, 8'h9B} >> 1, 4, 3);
        send_frame(17, {15'h0, 1'b1, 7'h04, 8'h9B, 1'b1}, 4, 3);
        send16(1'b1, 7'h04, 8'h40, 4, 3);
        drain();
        check("duty_after_len_err", {32'h0, pwm_duty_cycle}, 40'h40);

        send16(1'b1, 7'h01, 8'hAA, 3, 2);
        send16(1'b1, 7'h01, 8'h55, 3, 2);
        drain();

        all_regs(3);
        send16(1'b1, 7'h00, 8'h00, 3, 3);
        drain();
        all_regs(50);

        for (int k = 0; k < 40; k++) begin
            logic [15:0] f;
            logic [6:0]  a;
            int          len, hp, gap, sel;
            a   = ($urandom_range(0, 9) == 0) ? 7'h7F : 7'($urandom_range(0, 7));
            f   = {($urandom_range(0, 4) != 0), a, 8'($urandom)};
            sel = $urandom_range(0, 5);
            len = (sel == 0) ? 15 : (sel == 1) ? 17 : 16;
            hp  = $urandom_range(3, 8);
            gap = $urandom_range(2, 5);
            if (len == 15)      send_frame(15, {17'h0, f[15:1]}, hp, gap);
            else if (len == 17) send_frame(17, {15'h0, f, 1'($urandom)}, hp, gap);
            else                send_frame(16, {16'h0, f}, hp, gap);
        end
        drain();
        check("random_final", dut_vec, model_vec());

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
